// File: rtl/sweep_nco_if.sv
// Sample-stream bus between the sweep timing generator and the NCO.
// The master drives the enable, frequency and trigger inputs. The slave (the NCO) drives the quadrature samples.
interface sweep_nco_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         ipClkEnable;
    logic [31:0]                  ipFrequency;
    logic                         ipTrigger;
    logic signed [DATA_WIDTH-1:0] opSine;
    logic signed [DATA_WIDTH-1:0] opCosine;
    logic                         opValid;

    modport master (
        output ipClkEnable, ipFrequency, ipTrigger,
        input  opSine, opCosine, opValid
    );

    modport slave (
        input  ipClkEnable, ipFrequency, ipTrigger,
        output opSine, opCosine, opValid
    );
endinterface

// File: rtl/sweep_nco.sv
// Quadrature NCO with a phase-coherent sweep restart.
// The pipeline runs accumulator -> quadrant fold -> quarter-wave LUT -> sign.
// Every stage advances only on the sample-rate enable.
module sweep_nco #(
    parameter int LUT_BITS   = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic       ipClk,
    input  logic       Reset,
    sweep_nco_if.slave bus
);
    localparam int  DEPTH = 1 << LUT_BITS;
    localparam int  MAG_W = DATA_WIDTH - 1;
    localparam real PI    = 3.14159265358979323846;
    localparam real AMP   = real'((2 ** MAG_W) - 1);

    // Quarter-wave magnitude is sampled at the half-LSB point. This makes the mirrored quadrants land exactly on table entries.
    function automatic int magAt(input int k);
        real x;
        real term;
        real acc;
        x    = 2.0 * PI * (real'(k) + 0.5) / real'(4 * DEPTH);
        term = x;
        acc  = x;
        for (int n = 1; n < 14; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        return int'(acc * AMP);
    endfunction

    logic [MAG_W-1:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : gRom
        localparam int MagVal = magAt(k);
        assign rom[k] = MagVal[MAG_W-1:0];
    end

    logic                en;
    logic [31:0]         phase;
    logic [1:0]          quadSin, quadCos;
    logic [LUT_BITS-1:0] phaseIdx;
    logic [LUT_BITS-1:0] idxSin, idxCos;
    logic                negSin2, negCos2;
    logic [MAG_W-1:0]    magSin, magCos;
    logic                negSin3, negCos3;
    logic [2:0]          fillCnt;

    assign en       = bus.ipClkEnable;
    assign quadSin  = phase[31:30];
    // Cosine is sine advanced a quarter turn. That shifts only the quadrant bits.
    assign quadCos  = quadSin + 2'd1;
    assign phaseIdx = phase[29 -: LUT_BITS];

    // Stage 1: phase accumulator. A trigger zeroes the phase and ignores this cycle's frequency.
    always_ff @(posedge ipClk) begin
        if (Reset)
            phase <= '0;
        else if (en)
            phase <= bus.ipTrigger ? 32'd0 : phase + bus.ipFrequency;
    end

    // Stage 2: fold into the first quadrant. Odd quadrants mirror the index, and the upper half negates.
    always_ff @(posedge ipClk) begin
        if (Reset) begin
            idxSin  <= '0;
            idxCos  <= '0;
            negSin2 <= 1'b0;
            negCos2 <= 1'b0;
        end else if (en) begin
            idxSin  <= phaseIdx ^ {LUT_BITS{quadSin[0]}};
            idxCos  <= phaseIdx ^ {LUT_BITS{quadCos[0]}};
            negSin2 <= quadSin[1];
            negCos2 <= quadCos[1];
        end
    end

    // Stage 3: registered dual-port magnitude lookup. The sign flags travel alongside.
    always_ff @(posedge ipClk) begin
        if (Reset) begin
            magSin  <= '0;
            magCos  <= '0;
            negSin3 <= 1'b0;
            negCos3 <= 1'b0;
        end else if (en) begin
            magSin  <= rom[idxSin];
            magCos  <= rom[idxCos];
            negSin3 <= negSin2;
            negCos3 <= negCos2;
        end
    end

    logic signed [DATA_WIDTH-1:0] sinExt, cosExt;
    assign sinExt = $signed({1'b0, magSin});
    assign cosExt = $signed({1'b0, magCos});

    // Stage 4: apply the sign. The magnitude never exceeds 2^(W-1)-1, so the most-negative code never appears.
    always_ff @(posedge ipClk) begin
        if (Reset) begin
            bus.opSine   <= '0;
            bus.opCosine <= '0;
        end else if (en) begin
            bus.opSine   <= negSin3 ? -sinExt : sinExt;
            bus.opCosine <= negCos3 ? -cosExt : cosExt;
        end
    end

    // Valid pulses once per enabled advance after the pipe has filled. A trigger does not refill the pipe.
    always_ff @(posedge ipClk) begin
        if (Reset) begin
            fillCnt     <= '0;
            bus.opValid <= 1'b0;
        end else begin
            bus.opValid <= en && (fillCnt >= 3'd3);
            if (en && fillCnt != 3'd4)
                fillCnt <= fillCnt + 3'd1;
        end
    end
endmodule

// File: doc/sweep_nco.md
Name: sweep_nco

Overview:
- Numerically controlled oscillator directly downstream of the sweep timing generator.
- Consumes the per-sample frequency word and the sweep-restart trigger; produces quadrature sine/cosine samples for the DAC/mixer path.
- Phase accumulator feeding a quarter-wave LUT through a 4-stage pipeline that advances only on the shared sample clock enable.
- Phase is zeroed on every sweep restart, so each sweep is phase-coherent.

Parameters:
- LUT_BITS, 8, log2 of quarter-wave table depth (256 entries); phase address uses LUT_BITS+2 MSBs of the accumulator.
- DATA_WIDTH, 16, width of signed output samples; LUT stores DATA_WIDTH-1 bit magnitudes.

Ports:
- ipClk  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- ipClkEnable  input  1  sample-rate enable; the pipeline advances only when high.
- ipFrequency  input  32  phase increment per enabled cycle, unsigned, full scale = 2^32 = one turn.
- ipTrigger  input  1  sweep restart; qualified by ipClkEnable.
- opSine  output  DATA_WIDTH  signed sine sample.
- opCosine  output  DATA_WIDTH  signed cosine sample.
- opValid  output  1  one-clock pulse when opSine/opCosine have just updated with valid data.

Behaviour:
- Reset: clock ipClk; reset Reset, synchronous, active-high. On reset: phase accumulator = 0, all pipeline registers = 0, opSine = 0, opCosine = 0, opValid = 0, fill counter = 0. Reset overrides ipClkEnable. Reset mid-operation discards in-flight samples.
- Stage 1 (accumulator), on ipClkEnable:
  - if ipTrigger: phase <= 0, and ipFrequency is ignored that cycle;
  - else: phase <= phase + ipFrequency, mod 2^32 (natural wrap, no saturation).
- Stage 2 (fold), on ipClkEnable, for sine and for cosine (cosine uses phase + 2^30):
  - q = top 2 bits; idx = next LUT_BITS bits;
  - if q[0] = 1, idx <= ~idx;
  - register neg = q[1].
- Stage 3 (LUT): registered read of mag[idx], two read ports.
  - mag[k] = round((2^(DATA_WIDTH-1)-1) * sin(2*pi*(k+0.5)/2^(LUT_BITS+2))).
  - The half-LSB offset makes the fold exact; no special case at quadrant edges.
  - Table is generated at elaboration or from an init file.
- Stage 4 (sign): output = neg ? -mag : +mag. The result is never the most-negative code.
- Latency: a phase value loaded in stage 1 appears on the outputs after 3 further enabled cycles, so 4 enables from trigger to first output.
- Enable gating: when ipClkEnable is low, every stage holds and opValid = 0. Enable may have any duty cycle, including constantly high.
- opValid: registered; high on the clock after an enabled pipeline advance, only once the fill counter reaches 4 enables since reset. The counter saturates at 4. ipTrigger does not clear opValid, so a sweep restart keeps the stream continuous.
- Simultaneous trigger and frequency change: trigger wins, and the new frequency is first applied on the next enable.
- Throughput: one sample per enable, no backpressure.

Test Plan:
1. Reset, ipClkEnable = 1 constantly, ipFrequency = 0, ipTrigger pulsed once.
   -> After 4 enables: opSine = +101, opCosine = +32767, opValid high every cycle thereafter.
2. ipFrequency = 0x4000_0000 after trigger.
   -> (sine, cosine) repeats (101, 32767), (32767, -101), (-101, -32767), (-32767, 101).
3. ipFrequency = 0xC000_0000, checking accumulator wrap.
   -> Sequence is the reverse rotation: (101, 32767), (-32767, 101), (-101, -32767), (32767, -101).
4. ipClkEnable = 1 in 1 of every 5 clocks, same stimulus as scenario 2.
   -> Identical sample sequence; opValid is a 1-clock pulse after each enable; outputs are stable between enables.
5. Trigger asserted mid-sweep with ipFrequency = 0x0123_4567.
   -> The 4th enabled output after trigger is (101, 32767); opValid never drops.
6. Reset asserted for 1 clock mid-stream.
   -> Outputs = 0 and opValid = 0 next clock; opValid stays low for the next 4 enables, then resumes.
